mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM. It sits directly upstream of the PC register and drives its `pc_change` load enable and its next-PC mux select. It also sequences instruction-register write, memory access, ALU operand/operation selects and register-file writeback. Memory is single-port; it is shared for fetch and data, with a `mem_ready` wait handshake.

Parameters:
- STATE_W, 4, width of the state register / debug state output.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from the DECODE cycle to the end of the instruction.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_change`  out  1  PC load enable.
- `pc_source`  out  2  next-PC mux: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target.
- `i_or_d`  out  1  memory address: 0 PC, 1 ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  1  write register: 0 rt, 1 rd.
- `mem_to_reg`  out  1  writeback data: 0 ALUOut, 1 MDR.
- `alu_src_a`  out  1  ALU A: 0 PC, 1 reg A.
- `alu_src_b`  out  2  ALU B: 00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- `ext_zero`  out  1  immediate extension: 1 zero-extend, 0 sign-extend.
- `alu_ctrl`  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  STATE_W  current state, for debug.

Behaviour:
- Synchronous reset:
  - While `rst`=1, all enables and strobes (`pc_change`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `illegal_op`) are forced to 0.
  - At the clock edge with `rst`=1, the state becomes FETCH.
  - Reset mid-instruction abandons it; no partial write follows.
- Outputs are Moore-decoded from the state. Exceptions: `pc_change` and `ir_write` in FETCH (qualified by `mem_ready`), and `pc_change` in BRANCH (qualified by `zero`).
- Unlisted outputs default to 0. Default `alu_ctrl` is add.
- States and transitions:
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_source`=00. `ir_write` = `pc_change` = `mem_ready`. Stay while `mem_ready`=0, else go to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEM_ADDR
    - 000000 -> R_EXE
    - 001000 / 001100 / 001101 / 001010 (addi/andi/ori/slti) -> I_EXE
    - 000100 / 000101 (beq/bne) -> BRANCH
    - 000010 (j) -> JUMP
    - anything else -> FETCH, with `illegal_op`=1 for this cycle.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ext_zero`=0, add. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD: `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`, then MEM_WB.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. -> FETCH.
  - MEM_WR: `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`, then FETCH.
  - R_EXE: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Any other funct: add, and `illegal_op`=1 this cycle. Writeback still occurs.
    - -> R_WB.
  - R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. -> FETCH.
  - I_EXE: `alu_src_a`=1, `alu_src_b`=10. `ext_zero`=1 for andi/ori, else 0. `alu_ctrl`: addi add, andi and, ori or, slti slt. -> I_WB.
  - I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. `ext_zero` and `alu_ctrl` are held as in I_EXE. -> FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_source`=01. `pc_change` = `zero` for beq, `!zero` for bne. -> FETCH.
  - JUMP: `pc_source`=10, `pc_change`=1. -> FETCH.
- Cycle counts with `mem_ready` held at 1: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3.
- Each extra cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_read` and `mem_write` are never both 1.
- `pc_change` asserts at most once per instruction, except in FETCH followed by a taken BRANCH or a JUMP (two loads per instruction).
- State encoding is binary, 4 bits. Any unreachable code -> FETCH next cycle.

Decomposition:
- Shared package `mc_defs`:
  - state encodings
  - opcode and funct constants
  - `alu_ctrl` codes
  - `pc_source` / `alu_src_b` encodings
- One combinational sub-module, `alu_ctrl_dec`: inputs funct and opcode plus an R/I select; outputs `alu_ctrl`, `ext_zero` and an illegal flag.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles during MEM_RD -> all enables 0; state = FETCH the cycle after `rst` drops.
- lw with `mem_ready`=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. `pc_change`=1 only in FETCH. `reg_write`=1 with `mem_to_reg`=1 in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEM_WR -> `mem_write` held 4 cycles; `i_or_d`=1; no `reg_write`; back to FETCH.
- beq with `zero`=1, then bne with `zero`=1 -> beq: `pc_change`=1 with `pc_source`=01 in BRANCH. bne: `pc_change`=0 in BRANCH.
- R-type funct 101010 -> `alu_ctrl`=111 in R_EXE; `reg_write`=1, `reg_dst`=1 in R_WB. funct 000011 -> `illegal_op` pulse in R_EXE, `alu_ctrl`=010.
- ori opcode 001101 -> `ext_zero`=1, `alu_ctrl`=001. Opcode 111111 -> `illegal_op`=1 in DECODE, next state FETCH, no writes.

Source files
------------

// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings,
// opcode/funct constants, ALU operation codes and datapath mux encodings.
package mc_defs;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXE    = 4'd6,
    ST_R_WB     = 4'd7,
    ST_I_EXE    = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI,
      OP_SLTI, OP_BEQ, OP_BNE, OP_J: op_supported = 1'b1;
      default:                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decoder: funct field for R-type, opcode for I-type ALU ops.
// Also selects zero- vs sign-extension of the immediate.
module alu_ctrl_dec
  import mc_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       r_type,
  output logic [2:0] alu_ctrl,
  output logic       ext_zero,
  output logic       illegal
);

  // Unknown codes fall back to add and raise the illegal flag.
  always_comb begin
    alu_ctrl = ALU_ADD;
    ext_zero = 1'b0;
    illegal  = 1'b0;
    if (r_type) begin
      case (funct)
        FN_ADD:  alu_ctrl = ALU_ADD;
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: illegal  = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ADDI: alu_ctrl = ALU_ADD;
        OP_ANDI: begin alu_ctrl = ALU_AND; ext_zero = 1'b1; end
        OP_ORI:  begin alu_ctrl = ALU_OR;  ext_zero = 1'b1; end
        OP_SLTI: alu_ctrl = ALU_SLT;
        default: illegal  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Drives PC load/select, IR load, shared
// single-port memory strobes, ALU selects and register-file writeback.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_change,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [2:0]         alu_ctrl,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     cur_state;
  logic [2:0] dec_alu_ctrl;
  logic       dec_ext_zero;
  logic       dec_illegal;

  alu_ctrl_dec u_alu_ctrl_dec (
    .opcode   (opcode),
    .funct    (funct),
    .r_type   (cur_state == ST_R_EXE),
    .alu_ctrl (dec_alu_ctrl),
    .ext_zero (dec_ext_zero),
    .illegal  (dec_illegal)
  );

  // State sequencing; memory states hold until mem_ready, illegal/unreachable go to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_FETCH;
    end else begin
      case (cur_state)
        ST_FETCH:    if (mem_ready) cur_state <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:                      cur_state <= ST_MEM_ADDR;
            OP_RTYPE:                          cur_state <= ST_R_EXE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur_state <= ST_I_EXE;
            OP_BEQ, OP_BNE:                    cur_state <= ST_BRANCH;
            OP_J:                              cur_state <= ST_JUMP;
            default:                           cur_state <= ST_FETCH;
          endcase
        end
        ST_MEM_ADDR: cur_state <= (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (mem_ready) cur_state <= ST_MEM_WB;
        ST_MEM_WR:   if (mem_ready) cur_state <= ST_FETCH;
        ST_R_EXE:    cur_state <= ST_R_WB;
        ST_I_EXE:    cur_state <= ST_I_WB;
        default:     cur_state <= ST_FETCH;
      endcase
    end
  end

  // Moore output decode, with mem_ready qualifying FETCH loads and zero qualifying the branch.
  always_comb begin
    pc_change  = 1'b0;
    pc_source  = PCS_INC;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_zero   = 1'b0;
    alu_ctrl   = ALU_ADD;
    illegal_op = 1'b0;
    case (cur_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_change = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_BOFF;
        illegal_op = !op_supported(opcode);
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_R_EXE: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = dec_alu_ctrl;
        illegal_op = dec_illegal;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_I_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_zero  = dec_ext_zero;
        alu_ctrl  = dec_alu_ctrl;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        ext_zero  = dec_ext_zero;
        alu_ctrl  = dec_alu_ctrl;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_source = PCS_BR;
        pc_change = (opcode == OP_BEQ) ? zero : !zero;
      end
      ST_JUMP: begin
        pc_source = PCS_JMP;
        pc_change = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_change  = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = STATE_W'(cur_state);

endmodule
